// File: rtl/wam_pkg.sv
// Shared definitions for the whack-a-mole controller: state encoding,
// default timing constants and small arithmetic helpers.
package wam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_OVER   = 2'd3
    } state_t;

    localparam int GAME_SEC      = 30;
    localparam int TICKS_PER_SEC = 100;
    localparam int LIFE_UNIT     = 8;

    // Galois feedback mask for taps 16/14/13/11 in a right-shifting register
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Mole lifetime in ticks: (16 - hrdn) lifetime units, 8..128
    function automatic logic [7:0] life_len(input logic [3:0] hrdn);
        return 8'((16 - int'(hrdn)) * LIFE_UNIT);
    endfunction

    // Gap between moles in ticks: half a lifetime, 4..64
    function automatic logic [6:0] gap_len_of(input logic [3:0] hrdn);
        return 7'(((16 - int'(hrdn)) * LIFE_UNIT) / 2);
    endfunction

    // Three-digit BCD increment that sticks at 999
    function automatic logic [11:0] bcd_inc_sat(input logic [11:0] v);
        logic [3:0] d0;
        logic [3:0] d1;
        logic [3:0] d2;
        d0 = v[3:0];
        d1 = v[7:4];
        d2 = v[11:8];
        if (v == 12'h999) begin
            return v;
        end
        if (d0 != 4'd9) begin
            d0 = d0 + 4'd1;
        end else begin
            d0 = 4'd0;
            if (d1 != 4'd9) begin
                d1 = d1 + 4'd1;
            end else begin
                d1 = 4'd0;
                d2 = d2 + 4'd1;
            end
        end
        return {d2, d1, d0};
    endfunction

endpackage

// File: rtl/wam_lfsr.sv
// Free-running 16-bit Galois LFSR used to pick which hole the next mole uses.
module wam_lfsr
    import wam_pkg::*;
(
    input  logic        clk,
    input  logic        clr_n,
    input  logic [15:0] seed,
    output logic [15:0] out
);

    // Shift right every clock, folding the dropped bit back through the taps
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            out <= seed;
        end else begin
            out <= {1'b0, out[15:1]} ^ (out[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/wam_ctrl.sv
// Whack-a-mole game controller: round timer, mole spawn/expiry, hit
// detection and saturating BCD score.
module wam_ctrl #(
    parameter int          GAME_SEC      = wam_pkg::GAME_SEC,
    parameter int          TICKS_PER_SEC = wam_pkg::TICKS_PER_SEC,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        tick,
    input  logic        start,
    input  logic        pause,
    input  logic [3:0]  hrdn,
    input  logic [7:0]  tap,
    output logic [7:0]  holes,
    output logic [11:0] score,
    output logic [4:0]  time_display,
    output logic        running,
    output logic        game_over
);

    import wam_pkg::*;

    localparam int            PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    state_t        state;
    logic [PW-1:0] presc;
    logic [7:0]    life_cnt;
    logic [6:0]    gap_cnt;
    logic [6:0]    gap_len;
    logic [7:0]    tap_q;
    logic [7:0]    rise;
    logic          hit;
    logic          mole;
    logic          sec_wrap;
    logic [15:0]   lfsr_val;
    logic          unused_lfsr_bits;

    wam_lfsr u_lfsr (
        .clk   (clk),
        .clr_n (clr_n),
        .seed  (LFSR_SEED),
        .out   (lfsr_val)
    );

    // Only the low three LFSR bits choose a hole; the rest just carry the sequence
    assign unused_lfsr_bits = ^lfsr_val[15:3];

    assign rise     = tap & ~tap_q;
    assign mole     = |holes;
    assign hit      = |(rise & holes);
    assign sec_wrap = tick && (presc == PRESC_LAST);

    // Remember last tap levels so a held switch scores only on its rising edge
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            tap_q <= '0;
        end else begin
            tap_q <= tap;
        end
    end

    // Game FSM with mole, score and round-timer bookkeeping
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state        <= ST_IDLE;
            holes        <= '0;
            score        <= '0;
            time_display <= 5'(GAME_SEC);
            running      <= 1'b0;
            game_over    <= 1'b0;
            presc        <= '0;
            life_cnt     <= '0;
            gap_cnt      <= '0;
            gap_len      <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        state        <= ST_RUN;
                        running      <= 1'b1;
                        game_over    <= 1'b0;
                        score        <= '0;
                        time_display <= 5'(GAME_SEC);
                        holes        <= '0;
                        presc        <= '0;
                        life_cnt     <= '0;
                        gap_cnt      <= gap_len_of(hrdn);
                        gap_len      <= gap_len_of(hrdn);
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state   <= ST_PAUSED;
                        running <= 1'b0;
                    end else begin
                        if (hit) begin
                            holes   <= '0;
                            score   <= bcd_inc_sat(score);
                            gap_cnt <= gap_len;
                        end else if (tick) begin
                            if (mole) begin
                                if (life_cnt <= 8'd1) begin
                                    holes    <= '0;
                                    life_cnt <= '0;
                                    gap_cnt  <= gap_len;
                                end else begin
                                    life_cnt <= life_cnt - 8'd1;
                                end
                            end else begin
                                if (gap_cnt <= 7'd1) begin
                                    holes    <= 8'b0000_0001 << lfsr_val[2:0];
                                    life_cnt <= life_len(hrdn);
                                    gap_len  <= gap_len_of(hrdn);
                                    gap_cnt  <= '0;
                                end else begin
                                    gap_cnt <= gap_cnt - 7'd1;
                                end
                            end
                        end
                        if (tick) begin
                            if (sec_wrap) begin
                                presc <= '0;
                                if (time_display <= 5'd1) begin
                                    time_display <= '0;
                                    holes        <= '0;
                                    state        <= ST_OVER;
                                    running      <= 1'b0;
                                    game_over    <= 1'b1;
                                end else begin
                                    time_display <= time_display - 5'd1;
                                end
                            end else begin
                                presc <= presc + PW'(1);
                            end
                        end
                    end
                end
                ST_PAUSED: begin
                    if (pause) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    running   <= 1'b0;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wam_ctrl.sv
// Directed self-checking bench for wam_ctrl: a table of single-clock
// vectors for the opening of a round plus hand-written multi-cycle sequences.
module tb_wam_ctrl;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          NV   = 24;

    typedef struct {
        logic        s;
        logic        p;
        logic        t;
        logic [7:0]  tp;
        logic        e_run;
        logic        e_over;
        logic [4:0]  e_time;
        logic [11:0] e_score;
        logic [1:0]  e_mole;
    } vec_t;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        tick;
    logic        start;
    logic        pause;
    logic [3:0]  hrdn;
    logic [7:0]  tap;
    logic [7:0]  holes;
    logic [11:0] score;
    logic [4:0]  time_display;
    logic        running;
    logic        game_over;
    logic [7:0]  holes_big;
    logic [11:0] score_big;
    logic [4:0]  time_big;
    logic        running_big;
    logic        over_big;

    logic [15:0] m_lfsr;
    logic [15:0] m_prev;

    int checks = 0;
    int errors = 0;

    vec_t vecs [NV];

    wam_ctrl #(.GAME_SEC(30), .TICKS_PER_SEC(4), .LFSR_SEED(SEED)) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .tick         (tick),
        .start        (start),
        .pause        (pause),
        .hrdn         (hrdn),
        .tap          (tap),
        .holes        (holes),
        .score        (score),
        .time_display (time_display),
        .running      (running),
        .game_over    (game_over)
    );

    wam_ctrl #(.GAME_SEC(31), .TICKS_PER_SEC(250), .LFSR_SEED(SEED)) dut_big (
        .clk          (clk),
        .clr_n        (clr_n),
        .tick         (tick),
        .start        (start),
        .pause        (pause),
        .hrdn         (hrdn),
        .tap          (tap),
        .holes        (holes_big),
        .score        (score_big),
        .time_display (time_big),
        .running      (running_big),
        .game_over    (over_big)
    );

    always #5 clk = ~clk;

    // Reference hole-select sequence; m_prev is the value the DUT saw at the last edge
    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_lfsr <= SEED;
            m_prev <= SEED;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    // Abort if something stalls forever
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic s, input logic p, input logic t, input logic [7:0] tp,
                                input logic r, input logic o, input logic [4:0] tm,
                                input logic [11:0] sc, input logic [1:0] m);
        vec_t v;
        v.s = s; v.p = p; v.t = t; v.tp = tp;
        v.e_run = r; v.e_over = o; v.e_time = tm; v.e_score = sc; v.e_mole = m;
        return v;
    endfunction

    function automatic logic [1:0] moleClass(input logic [7:0] h);
        if (h == 8'h00) return 2'd0;
        if ($onehot(h)) return 2'd1;
        return 2'd2;
    endfunction

    task automatic applyStimulus(input logic s, input logic p, input logic t, input logic [7:0] tp);
        start = s;
        pause = p;
        tick  = t;
        tap   = tp;
        @(posedge clk);
        #1;
        start = 1'b0;
        pause = 1'b0;
        tick  = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic waitSpawn(output int n);
        logic [7:0] exp_hole;
        n = 0;
        while (holes == 8'h00 && n < 20) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
            n++;
        end
        exp_hole = 8'h01 << m_prev[2:0];
        checkOutput("spawn_hole", 32'(holes), 32'(exp_hole));
    endtask

    task automatic hitBig(output logic ok);
        int n;
        n = 0;
        while (holes_big == 8'h00 && n < 20) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
            n++;
        end
        ok = |holes_big;
        if (!ok) begin
            checkOutput("big_spawn", 32'(holes_big), 32'h1);
            return;
        end
        applyStimulus(1'b0, 1'b0, 1'b0, holes_big);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    endtask

    initial begin
        int         n;
        logic [7:0] saved;
        logic [7:0] wrong;
        logic [4:0] saved_time;
        logic       ok;

        // s p t tap | run over time score mole(0 none, 1 one-hot); hrdn=15: L=8, G=4
        vecs[0]  = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 5'd30, 12'h000, 2'd0);
        vecs[1]  = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd30, 12'h000, 2'd0);
        vecs[2]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd30, 12'h000, 2'd0);
        vecs[3]  = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 5'd30, 12'h000, 2'd0);
        vecs[4]  = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 5'd30, 12'h000, 2'd0);
        vecs[5]  = mk(1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 5'd30, 12'h000, 2'd0);
        vecs[6]  = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 5'd29, 12'h000, 2'd1);
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd29, 12'h000, 2'd1);
        vecs[8]  = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd29, 12'h000, 2'd1);
        vecs[9]  = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 5'd29, 12'h000, 2'd1);
        vecs[10] = mk(1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 5'd29, 12'h000, 2'd1);
        vecs[11] = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 5'd29, 12'h000, 2'd1);
        vecs[12] = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 5'd29, 12'h000, 2'd1);
        vecs[13] = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 5'd29, 12'h000, 2'd1);
        vecs[14] = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 5'd29, 12'h000, 2'd1);
        vecs[15] = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 5'd28, 12'h000, 2'd1);
        vecs[16] = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 5'd28, 12'h000, 2'd1);
        vecs[17] = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 5'd28, 12'h000, 2'd1);
        vecs[18] = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 5'd28, 12'h000, 2'd1);
        vecs[19] = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 5'd27, 12'h000, 2'd0);
        vecs[20] = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 5'd27, 12'h000, 2'd0);
        vecs[21] = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 5'd27, 12'h000, 2'd0);
        vecs[22] = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 5'd27, 12'h000, 2'd0);
        vecs[23] = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 5'd26, 12'h000, 2'd1);

        clr_n = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        tick  = 1'b0;
        tap   = 8'h00;
        hrdn  = 4'd15;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_running", 32'(running), 32'h0);
        checkOutput("rst_over", 32'(game_over), 32'h0);
        checkOutput("rst_time", 32'(time_display), 32'd30);
        checkOutput("rst_score", 32'(score), 32'h000);
        checkOutput("rst_holes", 32'(holes), 32'h00);
        checkOutput("rst_time_big", 32'(time_big), 32'd31);
        clr_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].s, vecs[i].p, vecs[i].t, vecs[i].tp);
            checkOutput($sformatf("vec%0d_running", i), 32'(running), 32'(vecs[i].e_run));
            checkOutput($sformatf("vec%0d_over", i), 32'(game_over), 32'(vecs[i].e_over));
            checkOutput($sformatf("vec%0d_time", i), 32'(time_display), 32'(vecs[i].e_time));
            checkOutput($sformatf("vec%0d_score", i), 32'(score), 32'(vecs[i].e_score));
            checkOutput($sformatf("vec%0d_mole", i), 32'(moleClass(holes)), 32'(vecs[i].e_mole));
        end

        // Wrong hole, then right hole, then every hole at once
        saved = holes;
        wrong = {saved[6:0], saved[7]};
        applyStimulus(1'b0, 1'b0, 1'b0, wrong);
        checkOutput("wrong_hole_score", 32'(score), 32'h000);
        checkOutput("wrong_hole_holes", 32'(holes), 32'(saved));
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, saved);
        checkOutput("hit_score", 32'(score), 32'h001);
        checkOutput("hit_holes", 32'(holes), 32'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        waitSpawn(n);
        checkOutput("gap_after_hit", 32'(n), 32'd4);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'hFF);
        checkOutput("multi_tap_score", 32'(score), 32'h002);
        checkOutput("multi_tap_holes", 32'(holes), 32'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

        // Hit lands on the same tick the mole would expire
        waitSpawn(n);
        checkOutput("gap_after_multi", 32'(n), 32'd4);
        saved = holes;
        repeat (7) applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("pre_expiry_holes", 32'(holes), 32'(saved));
        applyStimulus(1'b0, 1'b0, 1'b1, saved);
        checkOutput("hit_vs_expiry_score", 32'(score), 32'h003);
        checkOutput("hit_vs_expiry_holes", 32'(holes), 32'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

        // Pause mid-mole with taps; hrdn change must not touch the live mole
        waitSpawn(n);
        checkOutput("gap_after_hit_expiry", 32'(n), 32'd4);
        saved = holes;
        hrdn = 4'd0;
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        saved_time = time_display;
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("pause_running", 32'(running), 32'h0);
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, (i % 2 == 1) ? saved : 8'h00);
        end
        checkOutput("pause_holes", 32'(holes), 32'(saved));
        checkOutput("pause_time", 32'(time_display), 32'(saved_time));
        checkOutput("pause_score", 32'(score), 32'h003);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("unpause_running", 32'(running), 32'h1);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("resume_holes", 32'(holes), 32'(saved));
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("resume_expiry", 32'(holes), 32'h00);
        waitSpawn(n);
        checkOutput("gap_sampled", 32'(n), 32'd4);

        // Asynchronous reset in the middle of a round
        clr_n = 1'b0;
        #2;
        checkOutput("async_rst_running", 32'(running), 32'h0);
        checkOutput("async_rst_time", 32'(time_display), 32'd30);
        checkOutput("async_rst_score", 32'(score), 32'h000);
        checkOutput("async_rst_holes", 32'(holes), 32'h00);
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        hrdn = 4'd15;
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 8'h00);
        checkOutput("post_rst_idle", 32'(running), 32'h0);
        checkOutput("post_rst_time", 32'(time_display), 32'd30);

        // Full round: 30 s at 4 ticks/s ends after 120 ticks
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("round_start", 32'(running), 32'h1);
        n = 0;
        while (!game_over && n < 200) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
            n++;
            if (n % 4 == 0 && n < 120) begin
                checkOutput($sformatf("round_time_t%0d", n), 32'(time_display), 32'(30 - n / 4));
            end
        end
        checkOutput("round_ticks", 32'(n), 32'd120);
        checkOutput("round_over", 32'(game_over), 32'h1);
        checkOutput("round_running", 32'(running), 32'h0);
        checkOutput("round_time_end", 32'(time_display), 32'd0);
        checkOutput("round_holes_end", 32'(holes), 32'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("restart_running", 32'(running), 32'h1);
        checkOutput("restart_over", 32'(game_over), 32'h0);
        checkOutput("restart_time", 32'(time_display), 32'd30);

        // Score carry and saturation on the long-round instance
        clr_n = 1'b0;
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("big_start", 32'(running_big), 32'h1);
        for (int k = 1; k <= 1000; k++) begin
            hitBig(ok);
            if (!ok) break;
            if (k == 99)   checkOutput("score_099", 32'(score_big), 32'h099);
            if (k == 100)  checkOutput("score_100", 32'(score_big), 32'h100);
            if (k == 999)  checkOutput("score_999", 32'(score_big), 32'h999);
            if (k == 1000) checkOutput("score_sat", 32'(score_big), 32'h999);
        end
        checkOutput("big_still_running", 32'(running_big), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wam_ctrl.md
WAM_CTRL -- requirements
Module: wam_ctrl

Interface
REQ-001 SHALL have one clock, clk; reset is asynchronous and active-low, named clr_n.
REQ-002 Parameter GAME_SEC, 30, round length in seconds (max 31).
REQ-003 Parameter TICKS_PER_SEC, 100, number of tick strobes per second.
REQ-004 Parameter LFSR_SEED, 16'hACE1, reset value of the hole-select LFSR (non-zero).
REQ-005 Port clk, in, 1, system clock.
REQ-006 Port clr_n, in, 1, async active-low reset.
REQ-007 Port tick, in, 1, one-clk game-rate strobe; all timers advance only on tick.
REQ-008 Port start, in, 1, one-clk start pulse.
REQ-009 Port pause, in, 1, one-clk pause-toggle pulse.
REQ-010 Port hrdn, in, 4, difficulty 0 (easiest) to 15 (hardest).
REQ-011 Port tap, in, 8, debounced hit switches, level.
REQ-012 Port holes, out, 8, active mole mask, zero-hot or one-hot.
REQ-013 Port score, out, 12, three BCD digits, 000-999.
REQ-014 Port time_display, out, 5, seconds remaining, binary.
REQ-015 Port running, out, 1, high in RUN only.
REQ-016 Port game_over, out, 1, high in OVER only.

Function
REQ-017 FSM states: IDLE, RUN, PAUSED, OVER.
REQ-018 IDLE or OVER, start=1 -> RUN next clk: score=000, time_display=GAME_SEC, holes=0, second prescaler=0, gap counter=gap length.
REQ-019 start in RUN or PAUSED is ignored.
REQ-020 RUN, pause=1 -> PAUSED; PAUSED, pause=1 -> RUN; pause in IDLE/OVER ignored.
REQ-021 PAUSED freezes all counters and holes; taps are ignored.
REQ-022 Second prescaler counts ticks 0..TICKS_PER_SEC-1 in RUN; on wrap, time_display decrements by 1.
REQ-023 Decrement from 1 to 0 -> OVER on the same edge; holes cleared; score held.
REQ-024 Mole lifetime L = (16 - hrdn) x 8 ticks (range 8-128); gap G = L/2 ticks.
REQ-025 Mole lifetime L and gap G SHALL be sampled at spawn; a hrdn change mid-mole affects only the next mole.
REQ-026 No mole, gap counter at 0 on a tick -> spawn: holes = one-hot of lfsr[2:0]; the lifetime counter loads L.
REQ-027 Active mole, lifetime counter reaches 0 on a tick -> holes=0 and the gap counter loads G; no score change.
REQ-028 Tap edge detection: tap_q registers tap every clk; rise = tap & ~tap_q.
REQ-029 Hit means rise[i]=1 with holes[i]=1 in RUN -> on that edge, holes=0, score +1 BCD, gap counter loads G.
REQ-030 Rises on empty holes, or outside RUN, are ignored.
REQ-031 Score saturates at 999; BCD carries propagate within a single clk.
REQ-032 Simultaneous events: a hit beats expiry in the same clk; a hit on the final-second edge is scored, then OVER.
REQ-033 Multiple simultaneous rises: only a rise on the active hole counts (max +1 per clk).
REQ-034 LFSR: 16-bit Galois, taps 16/14/13/11, advances every clk in every state, never reaches 0.

Reset
REQ-035 clr_n=0 asynchronously forces: IDLE, holes=0, score=000, time_display=GAME_SEC, running=0, game_over=0, all counters=0, tap_q=0, LFSR=LFSR_SEED.
REQ-036 Reset mid-round discards the round; after release, the block waits in IDLE for start.

Structure
REQ-037 Shared package wam_pkg SHALL hold the FSM state encoding, GAME_SEC, TICKS_PER_SEC, and the lifetime unit (8).
REQ-038 The LFSR SHALL be a sub-module wam_lfsr (clk, clr_n, seed, out[15:0]); everything else is inline.

Verification
REQ-039 Reset then start, TICKS_PER_SEC=4, tick every clk: time_display goes 30,29,... and reaches 0 and OVER after 120 ticks; holes=0.
REQ-040 hrdn=15: mole appears, no tap -> holes clears after 8 ticks, next spawn 4 ticks later, score stays 000.
REQ-041 Tap the active hole: score 000->001 one clk after the tap rises, holes=0; tapping a wrong hole leaves score unchanged.
REQ-042 Preload score to 099 via 99 hits, hit again -> 100; at 999, a further hit stays 999.
REQ-043 Pause mid-mole for 50 ticks -> holes, time and counters unchanged; unpause -> they resume; taps during pause are ignored.
REQ-044 Hit and expiry in the same clk -> score +1; clr_n low mid-round -> immediate IDLE and reset values.
